// File: rtl/dmac_dest_fifo_buf_pkg.sv
// Shared definitions for the DMAC destination FIFO buffer.
// FSM encoding, response codes and a width helper.
package dmac_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_XFER  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmac_dest_fifo_buf_if.sv
// Source, request and response handshakes of the DMAC destination buffer.
// master drives beats/requests and acknowledges responses; slave is the buffer.
interface dmac_dest_fifo_buf_if #(
    parameter int C_DATA_WIDTH      = 64,
    parameter int C_BURST_LEN_WIDTH = 4
);
    logic                         fifo_valid;
    logic                         fifo_ready;
    logic [C_DATA_WIDTH-1:0]      fifo_data;

    logic                         req_valid;
    logic                         req_ready;
    logic [C_BURST_LEN_WIDTH-1:0] req_burst_length;
    logic                         req_eot;

    logic                         response_valid;
    logic                         response_ready;
    logic                         response_resp_eot;
    logic [1:0]                   response_resp;

    modport master (
        output fifo_valid, fifo_data,
        output req_valid, req_burst_length, req_eot,
        output response_ready,
        input  fifo_ready, req_ready,
        input  response_valid, response_resp_eot, response_resp
    );

    modport slave (
        input  fifo_valid, fifo_data,
        input  req_valid, req_burst_length, req_eot,
        input  response_ready,
        output fifo_ready, req_ready,
        output response_valid, response_resp_eot, response_resp
    );

endinterface

// File: rtl/dmac_dest_fifo_buf_sync_fifo.sv
// Synchronous FIFO storage with wrapping pointers and an occupancy count.
// Writes when full and reads when empty are ignored; no write-to-read bypass.
module dmac_sync_fifo
    import dmac_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr,
    input  logic [C_DATA_WIDTH-1:0]       wdata,
    input  logic                          rd,
    output logic [C_DATA_WIDTH-1:0]       rdata,
    output logic                          full,
    output logic                          empty,
    output logic [clog2(C_FIFO_DEPTH):0]  level
);
    localparam int AW = clog2(C_FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
    logic [AW-1:0]           wptr;
    logic [AW-1:0]           rptr;
    logic [LW-1:0]           cnt;
    logic                    wr_ok;
    logic                    rd_ok;

    assign full  = (cnt == LW'(C_FIFO_DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;
    assign rdata = mem[rptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-2 depth; count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/dmac_dest_fifo_buf.sv
// DMAC destination FIFO buffer: burst FSM, ID counters and sink read port.
// Optional DMAC_DEST_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module dmac_dest_fifo_buf
    import dmac_pkg::*;
#(
    parameter int C_ID_WIDTH        = 3,
    parameter int C_DATA_WIDTH      = 64,
    parameter int C_FIFO_DEPTH      = 8,
    parameter int C_BURST_LEN_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    output logic                          enabled,
    dmac_dest_fifo_buf_if.slave           bus,
    input  logic                          en,
    output logic [C_DATA_WIDTH-1:0]       dout,
    output logic                          valid,
    output logic                          underflow,
    output logic [clog2(C_FIFO_DEPTH):0]  level,
    output logic [C_ID_WIDTH-1:0]         data_id,
    output logic [C_ID_WIDTH-1:0]         response_id
`ifdef DMAC_DEST_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]                   underflow_count
`endif
);
    logic [1:0]                   state;
    logic [C_BURST_LEN_WIDTH-1:0] len_q;
    logic [C_BURST_LEN_WIDTH-1:0] beat_cnt;
    logic                         eot_q;
    logic                         wr;
    logic                         rd;
    logic                         full;
    logic                         empty;
    logic                         uf_next;
    logic [C_DATA_WIDTH-1:0]      rdata;

    assign enabled = (state != ST_IDLE) | enable;
    assign wr      = (state == ST_XFER) & bus.fifo_valid & ~full;
    assign rd      = en & ~empty & enabled;
    assign uf_next = enabled ? (en & empty) : en;

    // While disabled the source is drained into the void so it never stalls.
    assign bus.fifo_ready = (state == ST_XFER) ? ~full : ~enabled;
    assign bus.req_ready  = (state == ST_IDLE) & enable;

    assign bus.response_valid    = (state == ST_RESP);
    assign bus.response_resp_eot = eot_q;
    assign bus.response_resp     = RESP_OKAY;

    dmac_sync_fifo #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_FIFO_DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .wdata (bus.fifo_data),
        .rd    (rd),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Burst sequencing: accept request, count beats, respond, then drain if disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            len_q       <= '0;
            eot_q       <= 1'b0;
            beat_cnt    <= '0;
            data_id     <= '0;
            response_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!enable) begin
                        if (!empty) begin
                            state <= ST_DRAIN;
                        end
                    end else if (bus.req_valid) begin
                        len_q    <= bus.req_burst_length;
                        eot_q    <= bus.req_eot;
                        beat_cnt <= '0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (wr) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == len_q) begin
                            data_id <= data_id + 1'b1;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (bus.response_ready) begin
                        response_id <= response_id + 1'b1;
                        state       <= enable ? ST_IDLE : ST_DRAIN;
                    end
                end
                default: begin
                    if (empty) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Sink port: registered read data, valid and underflow one cycle after en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout      <= '0;
            valid     <= 1'b0;
            underflow <= 1'b0;
        end else begin
            valid     <= rd;
            underflow <= uf_next;
            if (rd) begin
                dout <= rdata;
            end
        end
    end

`ifdef DMAC_DEST_UNDERFLOW_CNT_EN
    // Saturating count of underflow cycles, stepping with the underflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            underflow_count <= '0;
        end else if (uf_next && underflow_count != 16'hFFFF) begin
            underflow_count <= underflow_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dmac_dest_fifo_buf.sv
// Scoreboard bench for dmac_dest_fifo_buf: directed bursts, full, drain, wrap, reset.
// Expected words and responses are queued at stimulus time and popped by a monitor.
module tb_dmac_dest_fifo_buf;

    localparam int IW    = 3;
    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int BLW   = 4;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          enable = 1'b0;
    logic          en     = 1'b0;
    logic          enabled;
    logic          valid;
    logic          underflow;
    logic [DW-1:0] dout;
    logic [3:0]    level;
    logic [IW-1:0] data_id;
    logic [IW-1:0] response_id;
`ifdef DMAC_DEST_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_count;
`endif

    dmac_dest_fifo_buf_if #(
        .C_DATA_WIDTH      (DW),
        .C_BURST_LEN_WIDTH (BLW)
    ) bus ();

    dmac_dest_fifo_buf #(
        .C_ID_WIDTH        (IW),
        .C_DATA_WIDTH      (DW),
        .C_FIFO_DEPTH      (DEPTH),
        .C_BURST_LEN_WIDTH (BLW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .enabled     (enabled),
        .bus         (bus.slave),
        .en          (en),
        .dout        (dout),
        .valid       (valid),
        .underflow   (underflow),
        .level       (level),
        .data_id     (data_id),
        .response_id (response_id)
`ifdef DMAC_DEST_UNDERFLOW_CNT_EN
        ,
        .underflow_count (underflow_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_data [$];
    logic          exp_eot  [$];
    logic [IW-1:0] exp_did  = '0;
    logic [IW-1:0] exp_rid  = '0;
    logic [DW-1:0] mon_d;
    logic          mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [BLW-1:0] len, input logic eot);
        int n;
        n = 0;
        bus.req_valid        = 1'b1;
        bus.req_burst_length = len;
        bus.req_eot          = eot;
        #1;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_wait", bus.req_ready, 1);
        if (bus.req_ready) begin
            exp_eot.push_back(eot);
            tick();
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.fifo_valid = 1'b1;
        bus.fifo_data  = d;
        #1;
        while (!bus.fifo_ready && n < 50) begin
            tick();
            n++;
        end
        check("fifo_ready_wait", bus.fifo_ready, 1);
        if (bus.fifo_ready) begin
            tick();
            exp_data.push_back(d);
        end
        bus.fifo_valid = 1'b0;
    endtask

    task automatic read_all();
        int n;
        n  = 0;
        en = 1'b1;
        while (level != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_level", level, 0);
        en = 1'b0;
        tick();
    endtask

    // Monitor: every valid word and every response handshake is scored here.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                checks++;
                if (exp_data.size() == 0) begin
                    failures++;
                    $display("FAIL dout_extra: got %0h expected no word", dout);
                end else begin
                    mon_d = exp_data.pop_front();
                    if (dout !== mon_d) begin
                        failures++;
                        $display("FAIL dout: got %0h expected %0h", dout, mon_d);
                    end
                end
            end
            if (bus.response_valid && bus.response_ready) begin
                checks += 2;
                if (exp_eot.size() == 0) begin
                    failures += 2;
                    $display("FAIL resp_extra: got eot %0b expected no response", bus.response_resp_eot);
                end else begin
                    mon_e = exp_eot.pop_front();
                    if (bus.response_resp_eot !== mon_e) begin
                        failures++;
                        $display("FAIL resp_eot: got %0b expected %0b", bus.response_resp_eot, mon_e);
                    end
                    if (bus.response_resp !== 2'b00) begin
                        failures++;
                        $display("FAIL resp_code: got %0b expected 0", bus.response_resp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fifo_valid       = 1'b0;
        bus.fifo_data        = '0;
        bus.req_valid        = 1'b0;
        bus.req_burst_length = '0;
        bus.req_eot          = 1'b0;
        bus.response_ready   = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_dout", dout, 0);
        check("rst_underflow", underflow, 0);
        check("rst_resp_valid", bus.response_valid, 0);
        check("rst_data_id", data_id, 0);
        check("rst_response_id", response_id, 0);
        reset = 1'b0;
        tick();
        check("dis_enabled", enabled, 0);
        check("dis_fifo_ready", bus.fifo_ready, 1);
        check("dis_req_ready", bus.req_ready, 0);

        // Underflow on empty read
        en = 1'b1;
        tick();
        en = 1'b0;
        check("uf_flag", underflow, 1);
        check("uf_valid", valid, 0);
`ifdef DMAC_DEST_UNDERFLOW_CNT_EN
        check("uf_count", underflow_count, 1);
`endif
        tick();
        check("uf_clear", underflow, 0);

        // Basic burst A..D with eot, held response
        enable = 1'b1;
        #1;
        check("en_enabled", enabled, 1);
        check("en_req_ready", bus.req_ready, 1);
        check("idle_fifo_ready", bus.fifo_ready, 0);
        do_req(4'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_beat(64'hA + 64'(i));
        end
        exp_did++;
        check("b1_resp_valid", bus.response_valid, 1);
        check("b1_resp_eot", bus.response_resp_eot, 1);
        check("b1_data_id", data_id, exp_did);
        check("b1_response_id", response_id, exp_rid);
        check("b1_level", level, 4);
        tick();
        check("b1_resp_held", bus.response_valid, 1);
        check("b1_eot_held", bus.response_resp_eot, 1);
        bus.response_ready = 1'b1;
        tick();
        exp_rid++;
        check("b1_response_id_ack", response_id, exp_rid);
        check("b1_resp_done", bus.response_valid, 0);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b1_valid_run", valid, 1);
        end
        en = 1'b0;
        tick();
        check("b1_valid_end", valid, 0);
        check("b1_level_end", level, 0);

        // Full buffer back-pressure, single read frees one slot
        do_req(4'd15, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_beat(64'h100 + 64'(i));
        end
        check("full_fifo_ready", bus.fifo_ready, 0);
        check("full_level", level, 8);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("full_level_rd", level, 7);
        check("full_ready_back", bus.fifo_ready, 1);
        en = 1'b1;
        for (int i = 8; i < 16; i++) begin
            send_beat(64'h100 + 64'(i));
        end
        exp_did++;
        check("b2_data_id", data_id, exp_did);
        read_all();
        exp_rid++;
        check("b2_response_id", response_id, exp_rid);

        // enable drops mid-burst; burst completes, then drain
        do_req(4'd3, 1'b1);
        send_beat(64'h300);
        send_beat(64'h301);
        enable = 1'b0;
        send_beat(64'h302);
        send_beat(64'h303);
        exp_did++;
        check("b3_data_id", data_id, exp_did);
        check("b3_resp_valid", bus.response_valid, 1);
        check("b3_enabled_resp", enabled, 1);
        tick();
        exp_rid++;
        check("b3_response_id", response_id, exp_rid);
        check("b3_enabled_drain", enabled, 1);
        check("b3_req_ready_drain", bus.req_ready, 0);
        check("b3_level_drain", level, 4);
        read_all();
        check("b3_enabled_off", enabled, 0);
        check("b3_fifo_ready_off", bus.fifo_ready, 1);
        bus.fifo_valid = 1'b1;
        bus.fifo_data  = 64'hDEAD;
        tick();
        bus.fifo_valid = 1'b0;
        tick();
        check("discard_level", level, 0);
        check("discard_valid", valid, 0);

        // Eight single-beat bursts: IDs wrap through 7 -> 0
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            do_req(4'd0, i[0]);
            send_beat(64'h200 + 64'(i));
            exp_did++;
            check("wrap_data_id", data_id, exp_did);
            tick();
            exp_rid++;
            check("wrap_response_id", response_id, exp_rid);
        end
        check("wrap_level", level, 8);
        read_all();

        // Reset mid-burst
        do_req(4'd3, 1'b0);
        send_beat(64'h400);
        send_beat(64'h401);
        reset = 1'b1;
        #2;
        check("mrst_level", level, 0);
        check("mrst_valid", valid, 0);
        check("mrst_dout", dout, 0);
        check("mrst_resp_valid", bus.response_valid, 0);
        check("mrst_data_id", data_id, 0);
        check("mrst_response_id", response_id, 0);
`ifdef DMAC_DEST_UNDERFLOW_CNT_EN
        check("mrst_uf_count", underflow_count, 0);
`endif
        exp_data.delete();
        exp_eot.delete();
        exp_did = '0;
        exp_rid = '0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_resp", bus.response_valid, 0);
        check("post_rst_req_ready", bus.req_ready, 1);
        check("post_rst_level", level, 0);

        tick();
        check("sb_data_left", exp_data.size(), 0);
        check("sb_resp_left", exp_eot.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmac_dest_fifo_buf.md
DMAC_DEST_FIFO_BUF -- requirements
Module: dmac_dest_fifo_buf

Interface
REQ-001 Parameter C_ID_WIDTH, default 3, width of the burst ID counters.
REQ-002 Parameter C_DATA_WIDTH, default 64, data word width.
REQ-003 Parameter C_FIFO_DEPTH, default 8, output buffer depth in words; power of 2, minimum 2.
REQ-004 Parameter C_BURST_LEN_WIDTH, default 4, width of the burst length field.
REQ-005 One clock; reset is asynchronous and active-high. Ports: clk input 1, system clock; reset input 1, async active-high reset.
REQ-006 Control ports: enable input 1, block enable; enabled output 1, block active or draining.
REQ-007 Source ports: fifo_valid input 1; fifo_ready output 1; fifo_data input C_DATA_WIDTH.
REQ-008 Request ports: req_valid input 1; req_ready output 1; req_burst_length input C_BURST_LEN_WIDTH, beats minus 1; req_eot input 1, last burst of transfer.
REQ-009 Sink ports: en input 1, read strobe; dout output C_DATA_WIDTH; valid output 1; underflow output 1; level output log2(C_FIFO_DEPTH)+1, buffer occupancy.
REQ-010 Response ports: response_valid output 1; response_ready input 1; response_resp_eot output 1; response_resp output 2.
REQ-011 ID ports: data_id output C_ID_WIDTH, count of completed bursts; response_id output C_ID_WIDTH, count of acknowledged responses.

Function
REQ-012 FSM states: IDLE, XFER, RESP, DRAIN.
REQ-013 IDLE: req_ready=1 when enable=1. On req_valid&req_ready: latch length and eot, clear beat_cnt, go to XFER.
REQ-014 XFER: fifo_ready=1 when level<C_FIFO_DEPTH. Each fifo_valid&fifo_ready beat is written to the buffer and increments beat_cnt.
REQ-015 XFER: the beat with beat_cnt==latched length ends the burst. data_id increments modulo 2^C_ID_WIDTH in the same cycle, and the FSM goes to RESP.
REQ-016 RESP: response_valid=1, response_resp_eot=latched eot, response_resp=2'b00; values held stable until response_ready.
REQ-017 RESP: on the response handshake, response_id increments modulo 2^C_ID_WIDTH. Next state is IDLE if enable=1, else DRAIN.
REQ-018 Read side: en=1 with level>0 in cycle n gives dout=oldest word and valid=1 in cycle n+1; otherwise valid=0 in n+1 and dout holds its last value.
REQ-019 Read side: en=1 with level==0 in cycle n gives underflow=1 in cycle n+1; underflow=0 otherwise.
REQ-020 No write-to-read bypass: a word written in cycle n is readable from cycle n+1. A simultaneous write and read leaves level unchanged.
REQ-021 Pointers wrap modulo C_FIFO_DEPTH. Full (level==C_FIFO_DEPTH) deasserts fifo_ready with no overwrite.
REQ-022 enable falling in XFER: the current burst completes normally, through RESP, then DRAIN.
REQ-023 enable falling in IDLE: go to DRAIN directly.
REQ-024 DRAIN: req_ready=0. Sink reads continue until level==0, then go to IDLE with enabled=0.
REQ-025 enabled=1 in XFER, RESP, DRAIN, and in IDLE when enable=1.
REQ-026 When enabled=0: fifo_ready=1 and incoming beats are discarded; valid=0; underflow=en registered.

Reset
REQ-027 Reset asserted asynchronously forces:
- FSM=IDLE; pointers, level, beat_cnt, data_id, response_id = 0.
- valid, underflow, response_valid = 0; dout = 0.
REQ-028 Reset asserted mid-burst abandons the burst with no response. Buffer contents are discarded.
REQ-029 Reset deassertion is used synchronously to clk.

Configuration
REQ-030 Macro DMAC_DEST_UNDERFLOW_CNT_EN defined: adds output underflow_count, 16 bits, which increments on each cycle underflow=1, saturates at 0xFFFF, and clears on reset.
REQ-031 Macro absent: the underflow_count port and its counter do not exist.

Structure
REQ-032 Shared package dmac_pkg holds:
- FSM state encoding;
- response code constant RESP_OKAY=2'b00;
- a clog2 function for the level and pointer widths.
REQ-033 The buffer storage and pointers are one sub-module, dmac_sync_fifo, with write/read strobes, full/empty flags and level. The FSM and ID logic live in the top.

Verification
REQ-034 Req length 3 eot 1, four fifo beats 0xA..0xD, en held -> valid on four consecutive cycles with dout A,B,C,D; response_valid with resp_eot=1; data_id=1, then response_id=1 after the handshake.
REQ-035 Depth 8, burst length 15, en=0 -> fifo_ready drops after 8 beats with level=8; en=1 for one cycle -> level=7 and fifo_ready reasserts.
REQ-036 en=1 with empty buffer -> underflow=1 the next cycle, valid=0; with the macro defined, underflow_count=1.
REQ-037 enable dropped mid-burst (beat 2 of 4) -> remaining 2 beats still accepted, response issued, DRAIN empties the buffer, then enabled=0 and fifo_ready=1.
REQ-038 Eight back-to-back bursts with C_ID_WIDTH=3 -> data_id and response_id wrap 7->0.
REQ-039 reset pulse during XFER -> all outputs at reset values immediately, no response_valid, level=0.
